// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions for the hart/memory interconnect.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Widest address any master in the SoC may present; narrower buses zero-extend.
  localparam int unsigned AHB_ADDR_MAX = 64;

  typedef struct packed {
    logic [AHB_ADDR_MAX-1:0] addr;
    logic                    write;
    logic [2:0]              size;
    logic                    excl;
  } ahb_req_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_hart_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick
  import ahb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/ahb_hart_mem_arbiter.sv
// Round-robin AHB-lite arbiter sharing one memory slave between per-hart masters,
// with a one-entry hold buffer per hart for address phases that lose arbitration.
module ahb_hart_mem_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*N_PORTS-1:0]      src_htrans,
  input  logic [W_ADDR*N_PORTS-1:0] src_haddr,
  input  logic [N_PORTS-1:0]        src_hwrite,
  input  logic [N_PORTS-1:0]        src_hexcl,
  input  logic [3*N_PORTS-1:0]      src_hsize,
  input  logic [W_DATA*N_PORTS-1:0] src_hwdata,
  output logic [N_PORTS-1:0]        src_hready,
  output logic [N_PORTS-1:0]        src_hresp,
  output logic [N_PORTS-1:0]        src_hexokay,
  output logic [W_DATA-1:0]         src_hrdata,
  output logic [1:0]                dst_htrans,
  output logic [W_ADDR-1:0]         dst_haddr,
  output logic                      dst_hwrite,
  output logic [2:0]                dst_hsize,
  output logic                      dst_hexcl,
  output logic [7:0]                dst_hmaster,
  output logic                      dst_hready,
  output logic [W_DATA-1:0]         dst_hwdata,
  input  logic                      dst_hready_resp,
  input  logic                      dst_hresp,
  input  logic                      dst_hexokay,
  input  logic [W_DATA-1:0]         dst_hrdata
);

  localparam int unsigned IW = idx_w(N_PORTS);

  logic [N_PORTS-1:0] live, cand, pick_oh, gnt_oh, pend_v, own;
  ahb_req_t           live_req [N_PORTS];
  ahb_req_t           pend_q   [N_PORTS];
  ahb_req_t           win_req;
  logic [IW-1:0]      rr_ptr, win_idx, dp_owner, next_ptr;
  logic               any, grant, dp_valid;
  logic               unused_addr_hi;

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      live[p]           = src_htrans[2*p+1] & src_hready[p];
      live_req[p].addr  = AHB_ADDR_MAX'(src_haddr[p*W_ADDR +: W_ADDR]);
      live_req[p].write = src_hwrite[p];
      live_req[p].size  = src_hsize[3*p +: 3];
      live_req[p].excl  = src_hexcl[p];
    end
  end

  // hready is low while a buffer is full, so pend_v and live never overlap per port.
  assign cand = pend_v | live;

  rr_pick #(.N(N_PORTS)) u_pick (
    .req (cand),
    .ptr (rr_ptr),
    .gnt (pick_oh),
    .idx (win_idx),
    .any (any)
  );

  assign grant    = any & dst_hready_resp;
  assign gnt_oh   = grant ? pick_oh : '0;
  assign win_req  = pend_v[win_idx] ? pend_q[win_idx] : live_req[win_idx];
  assign next_ptr = (win_idx == IW'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;

  assign dst_htrans     = grant ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign dst_haddr      = win_req.addr[W_ADDR-1:0];
  assign dst_hwrite     = win_req.write;
  assign dst_hsize      = win_req.size;
  assign dst_hexcl      = win_req.excl;
  assign dst_hmaster    = grant ? 8'(win_idx) : '0;
  assign dst_hready     = dst_hready_resp;
  assign dst_hwdata     = src_hwdata[32'(dp_owner)*W_DATA +: W_DATA];
  assign src_hrdata     = dst_hrdata;
  assign unused_addr_hi = ^(win_req.addr >> W_ADDR);

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      own[p]         = dp_valid && (dp_owner == IW'(p));
      src_hready[p]  = own[p] ? dst_hready_resp : ~pend_v[p];
      src_hresp[p]   = own[p] & dst_hresp;
      src_hexokay[p] = own[p] ? dst_hexokay : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      pend_v   <= '0;
      dp_valid <= 1'b0;
      dp_owner <= '0;
      for (int unsigned p = 0; p < N_PORTS; p++) pend_q[p] <= '0;
    end else begin
      if (grant) begin
        rr_ptr   <= next_ptr;
        dp_owner <= win_idx;
        dp_valid <= 1'b1;
      end else if (dst_hready_resp) begin
        dp_valid <= 1'b0;
      end
      // A same-cycle grant beats latching, so a winning live request never fills its buffer.
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (gnt_oh[p]) begin
          pend_v[p] <= 1'b0;
        end else if (live[p]) begin
          pend_v[p] <= 1'b1;
          pend_q[p] <= live_req[p];
        end
      end
    end
  end

`ifdef SIM_MODE
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (rst_n && src_htrans[2*p]) begin
        $display("ahb_hart_mem_arbiter: illegal SEQ/BUSY on port %0d", p);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_hart_mem_arbiter.sv
// Scoreboard bench for ahb_hart_mem_arbiter: directed hart traffic, expected grants and data phases queued.
module tb_ahb_hart_mem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned WA = 32;
  localparam int unsigned WD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*N-1:0]  src_htrans;
  logic [WA*N-1:0] src_haddr;
  logic [N-1:0]    src_hwrite, src_hexcl;
  logic [3*N-1:0]  src_hsize;
  logic [WD*N-1:0] src_hwdata;
  logic [N-1:0]    src_hready, src_hresp, src_hexokay;
  logic [WD-1:0]   src_hrdata;
  logic [1:0]      dst_htrans;
  logic [WA-1:0]   dst_haddr;
  logic            dst_hwrite, dst_hexcl, dst_hready;
  logic [2:0]      dst_hsize;
  logic [7:0]      dst_hmaster;
  logic [WD-1:0]   dst_hwdata;
  logic            dst_hready_resp, dst_hresp, dst_hexokay;
  logic [WD-1:0]   dst_hrdata;

  ahb_hart_mem_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_htrans(src_htrans), .src_haddr(src_haddr), .src_hwrite(src_hwrite),
    .src_hexcl(src_hexcl), .src_hsize(src_hsize), .src_hwdata(src_hwdata),
    .src_hready(src_hready), .src_hresp(src_hresp), .src_hexokay(src_hexokay),
    .src_hrdata(src_hrdata),
    .dst_htrans(dst_htrans), .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
    .dst_hsize(dst_hsize), .dst_hexcl(dst_hexcl), .dst_hmaster(dst_hmaster),
    .dst_hready(dst_hready), .dst_hwdata(dst_hwdata),
    .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_hexokay(dst_hexokay), .dst_hrdata(dst_hrdata)
  );

  typedef struct { logic [31:0] addr; logic write; logic excl; logic [31:0] data; } cmd_t;
  typedef struct { int unsigned port; logic [31:0] addr; logic write; logic excl; } gexp_t;
  typedef struct { int unsigned port; logic write; logic [31:0] data; logic exok; } dexp_t;

  cmd_t  q0[$], q1[$];
  gexp_t exp_g[$];
  dexp_t exp_d[$];
  logic  ap_act [N];
  cmd_t  ap_cmd [N];
  logic [N-1:0] hr_s = '1;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {src_hready, src_hresp, src_hexokay, dst_htrans, dst_hmaster},
        {2'b11, 2'b00, 2'b11, 2'b00, 8'h00});
  endtask

  task automatic push_cmd(input int unsigned p, input logic [31:0] a, input logic w,
                          input logic x, input logic [31:0] d);
    cmd_t c;
    c = '{addr: a, write: w, excl: x, data: d};
    if (p == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  task automatic expect_g(input int unsigned p, input logic [31:0] a, input logic w, input logic x);
    exp_g.push_back('{port: p, addr: a, write: w, excl: x});
  endtask

  task automatic expect_d(input int unsigned p, input logic w, input logic [31:0] d, input logic ok);
    exp_d.push_back('{port: p, write: w, data: d, exok: ok});
  endtask

  task automatic clear_masters();
    q0.delete();
    q1.delete();
    for (int p = 0; p < N; p++) ap_act[p] = 1'b0;
    src_htrans = '0; src_haddr = '0; src_hwrite = '0; src_hexcl = '0; src_hwdata = '0;
  endtask

  // Advance one clock; each AHB master moves on when it saw hready high at the edge.
  task automatic step(input logic rdy, input logic exok);
    cmd_t c;
    logic got;
    @(posedge clk); #1;
    dst_hready_resp = rdy;
    dst_hexokay     = exok;
    for (int p = 0; p < N; p++) begin
      if (hr_s[p]) begin
        c   = '{addr: 0, write: 0, excl: 0, data: 0};
        got = 1'b0;
        if (ap_act[p]) src_hwdata[p*WD +: WD] = ap_cmd[p].data;
        if (p == 0 && q0.size() > 0) begin c = q0.pop_front(); got = 1'b1; end
        if (p == 1 && q1.size() > 0) begin c = q1.pop_front(); got = 1'b1; end
        ap_act[p] = got;
        if (got) ap_cmd[p] = c;
        src_htrans[2*p +: 2]  = got ? 2'b10 : 2'b00;
        src_haddr[p*WA +: WA] = got ? c.addr : '0;
        src_hwrite[p]         = got & c.write;
        src_hexcl[p]          = got & c.excl;
      end
    end
  endtask

  task automatic do_reset();
    chk("drained_before_reset", 64'(exp_g.size() + exp_d.size()), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_masters();
    dst_hready_resp = 1'b1;
    dst_hexokay     = 1'b1;
    @(negedge clk);
    chk_reset("reset_values");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    hr_s = src_hready;
  end

  initial begin : monitor
    logic dp_act;
    gexp_t g;
    dexp_t d;
    logic [N-1:0] ok_v;
    dp_act = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp_act = 1'b0;
      end else begin
        if (dp_act && dst_hready_resp) begin
          if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL dp_unexpected actual_hready=%b required=no data phase @%0t", src_hready, $time);
          end else begin
            d = exp_d.pop_front();
            ok_v = 2'b11;
            ok_v[d.port] = d.exok;
            if (d.write) chk("dp_hwdata", dst_hwdata, d.data);
            chk("dp_hexokay", src_hexokay, ok_v);
            chk("dp_hready_owner", src_hready[d.port], 1'b1);
            chk("dp_hresp", src_hresp, 2'b00);
          end
        end
        if (dst_htrans == 2'b10) begin
          if (exp_g.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected actual_hmaster=%0d haddr=%h required=IDLE @%0t",
                     dst_hmaster, dst_haddr, $time);
          end else begin
            g = exp_g.pop_front();
            chk("grant_hmaster", dst_hmaster, g.port);
            chk("grant_haddr", dst_haddr, g.addr);
            chk("grant_hwrite", dst_hwrite, g.write);
            chk("grant_hexcl", dst_hexcl, g.excl);
            chk("grant_hsize", dst_hsize, 3'b010);
          end
          dp_act = 1'b1;
        end else if (dst_hready_resp) begin
          dp_act = 1'b0;
        end
      end
    end
  end

  initial begin
    clear_masters();
    src_hsize       = {N{3'b010}};
    dst_hready_resp = 1'b1;
    dst_hresp       = 1'b0;
    dst_hexokay     = 1'b1;
    dst_hrdata      = 32'hCAFE_0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_initial");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Uncontended read passes through in its own cycle.
    push_cmd(0, 32'h8000_0010, 1'b0, 1'b0, 32'h0);
    expect_g(0, 32'h8000_0010, 1'b0, 1'b0);
    expect_d(0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("t1_same_cycle_nonseq", dst_htrans, 2'b10);
    chk("t1_no_wait_hready0", src_hready[0], 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("t1_hrdata", src_hrdata, 32'hCAFE_0010);
    step(1'b1, 1'b1);

    // Simultaneous writes from pointer 0: port 0 first, port 1 from its buffer.
    do_reset();
    push_cmd(0, 32'h0000_0200, 1'b1, 1'b0, 32'hD0D0_0000);
    push_cmd(1, 32'h0000_0300, 1'b1, 1'b0, 32'hD1D1_1111);
    expect_g(0, 32'h0000_0200, 1'b1, 1'b0);
    expect_g(1, 32'h0000_0300, 1'b1, 1'b0);
    expect_d(0, 1'b1, 32'hD0D0_0000, 1'b1);
    expect_d(1, 1'b1, 32'hD1D1_1111, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("t2_hready1_buffered", src_hready[1], 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Slave stalled for five cycles while port 1 requests.
    push_cmd(1, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
    expect_g(1, 32'h0000_0400, 1'b0, 1'b0);
    expect_d(1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk("t3_idle_while_stalled", dst_htrans, 2'b00);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk("t3_hready1_low_stalled", src_hready[1], 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("t3_hready1_low_at_issue", src_hready[1], 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Exclusive pair on port 0 with a port 1 write in between; SC fails at the slave.
    push_cmd(0, 32'h0000_0100, 1'b0, 1'b1, 32'h0);
    push_cmd(0, 32'h0000_0100, 1'b1, 1'b1, 32'h5C5C_0001);
    expect_g(0, 32'h0000_0100, 1'b0, 1'b1);
    expect_g(1, 32'h0000_0100, 1'b1, 1'b0);
    expect_g(0, 32'h0000_0100, 1'b1, 1'b1);
    expect_d(0, 1'b0, 32'h0, 1'b1);
    expect_d(1, 1'b1, 32'h1111_2222, 1'b1);
    expect_d(0, 1'b1, 32'h5C5C_0001, 1'b0);
    step(1'b1, 1'b1);
    push_cmd(1, 32'h0000_0100, 1'b1, 1'b0, 32'h1111_2222);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("t4_sc_buffered_hready0", src_hready[0], 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Continuous traffic on both ports alternates 0,1,0,1.
    do_reset();
    for (int k = 0; k < 50; k++) begin
      push_cmd(0, 32'h1000 + 32'(4*k), 1'b1, 1'b0, 32'hA000_0000 + 32'(k));
      push_cmd(1, 32'h2000 + 32'(4*k), 1'b1, 1'b0, 32'hB000_0000 + 32'(k));
      expect_g(0, 32'h1000 + 32'(4*k), 1'b1, 1'b0);
      expect_g(1, 32'h2000 + 32'(4*k), 1'b1, 1'b0);
      expect_d(0, 1'b1, 32'hA000_0000 + 32'(k), 1'b1);
      expect_d(1, 1'b1, 32'hB000_0000 + 32'(k), 1'b1);
    end
    repeat (102) step(1'b1, 1'b1);

    // Reset while port 1 sits in its buffer.
    do_reset();
    push_cmd(0, 32'h0000_3000, 1'b0, 1'b0, 32'h0);
    push_cmd(1, 32'h0000_3004, 1'b0, 1'b0, 32'h0);
    expect_g(0, 32'h0000_3000, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst_n = 1'b0;
    clear_masters();
    @(negedge clk);
    chk_reset("t6_reset_mid_transfer");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      @(negedge clk);
      chk("t6_no_ghost_nonseq", dst_htrans, 2'b00);
      chk("t6_buffer_dropped", src_hready, 2'b11);
    end

    chk("scoreboard_drained", 64'(exp_g.size() + exp_d.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_hart_mem_arbiter.md
# ahb_hart_mem_arbiter

Round-robin AHB-lite arbiter that shares the single SDRAM/cache memory slave (`ahb_sync_sram`) between the per-hart AHB-lite masters. It queues one losing address phase per hart, replays it when the slave is free, and steers write data, read data, hready and exclusive-access status by data-phase owner. It also drives `hmaster` so the slave's exclusive monitor sees the correct hart index. It sits between the hart bus ports and the memory slave in the example SoC.

## Interface
- `N_PORTS`, 2: number of upstream masters (harts), 2..8.
- `W_ADDR`, 32: address width.
- `W_DATA`, 32: data width.
- `clk` in 1: system clock, same domain as the memory slave.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_htrans` in 2*N_PORTS: per-port HTRANS; only IDLE/NONSEQ are legal.
- `src_haddr` in W_ADDR*N_PORTS: per-port HADDR.
- `src_hwrite`, `src_hexcl` in N_PORTS: per-port HWRITE and HEXCL.
- `src_hsize` in 3*N_PORTS: per-port HSIZE.
- `src_hwdata` in W_DATA*N_PORTS: per-port HWDATA.
- `src_hready` out N_PORTS: per-port HREADY.
- `src_hresp`, `src_hexokay` out N_PORTS: per-port HRESP and HEXOKAY.
- `src_hrdata` out W_DATA: read data, broadcast to all ports.
- `dst_htrans` out 2: downstream HTRANS (IDLE/NONSEQ).
- `dst_haddr`, `dst_hwrite`, `dst_hsize`, `dst_hexcl` out: downstream address phase.
- `dst_hmaster` out 8: index of the address-phase winner.
- `dst_hready` out 1: downstream HREADY input, equal to `dst_hready_resp`.
- `dst_hwdata` out W_DATA: write data from the data-phase owner.
- `dst_hready_resp`, `dst_hresp`, `dst_hexokay` in 1: downstream response signals.
- `dst_hrdata` in W_DATA: downstream read data.

## Operation
- Port request: a live request is `src_htrans[p][1] && src_hready[p]`. A pending request is a full hold buffer `pend_v[p]`.
- Each port has a one-entry hold buffer holding addr, write, size and excl.
- Candidate set, evaluated per cycle: port p is a candidate if `pend_v[p]` is set, or if it has a live request. The buffer takes precedence over a live request; a port never has both, because hready is low while its buffer is full.
- Grant: a grant is issued only when `dst_hready_resp`=1 and at least one candidate exists.
  - The winner is the first candidate at or after `rr_ptr`, cyclically.
  - On a grant, `rr_ptr` <= winner+1 (mod N_PORTS).
  - `dst_*` carry the winner's fields with `dst_htrans`=NONSEQ and `dst_hmaster`=winner.
  - With no grant, `dst_htrans`=IDLE and the other `dst_*` fields are don't-care.
- Losers: a live request that loses, or that arrives while `dst_hready_resp`=0, is latched into its buffer and `pend_v[p]` is set. A granted buffered request clears `pend_v[p]`.
- Data-phase owner: on each grant, `dp_owner` <= winner and `dp_valid` <= 1. When `dst_hready_resp`=1 with no grant, `dp_valid` <= 0.
- `dst_hwdata` = `src_hwdata[dp_owner]`. The master keeps hwdata stable while stalled.
- `src_hready[p]`:
  - `dst_hready_resp` if `dp_valid` and `dp_owner`==p;
  - else 0 if `pend_v[p]`;
  - else 1.
- `src_hresp[p]` and `src_hexokay[p]` follow `dst_hresp`/`dst_hexokay` for the data-phase owner. For other ports, hresp=0 and hexokay=1.
- Illegal input: SEQ/BUSY on any port is an error. Assert under SIM_MODE with `$display` and `$finish`.

## Timing
- Reset values: `src_hready`=all 1, `src_hresp`=0, `src_hexokay`=all 1, `dst_htrans`=IDLE, `dst_hmaster`=0, `rr_ptr`=0, `pend_v`=0, `dp_valid`=0.
- Zero added latency for an uncontended request: the address phase passes combinationally in the same cycle.
- A buffered request is issued at the earliest cycle in which `dst_hready_resp`=1 and it wins round-robin.
- Worst-case wait is N_PORTS-1 grants (starvation-free).
- Buffered losers re-enter arbitration on the next cycle.
- Simultaneous grant and latch: a port can be granted in the same cycle its buffer would be latched; the grant wins and the buffer is not set.
- Back-to-back grants are allowed every cycle `dst_hready_resp`=1. Owner and address phase change in the same cycle.
- Reset asserted mid-transfer clears all state immediately. Buffered requests are dropped; masters are reset alongside.

## Structure
- Shared package `ahb_pkg`: `HTRANS_IDLE`/`HTRANS_NONSEQ` constants and the `ahb_req_t` fields (addr, write, size, excl).
- Sub-module `rr_pick #(N)`: inputs are the request vector and the pointer; outputs are a one-hot grant, the index and `any`. It is purely combinational and reused by future peripheral arbiters.

## Test plan
- Single port, N=2, port 0 reads 0x8000_0010 with the slave ready → `dst_htrans`=NONSEQ in the same cycle, `dst_hmaster`=0, no added wait.
- Both ports issue writes in the same cycle, `rr_ptr`=0 → port 0 is granted first. Port 1 is buffered with `src_hready[1]`=0, is issued next cycle with `dst_hmaster`=1, and `dst_hwdata` equals port 1's data.
- `dst_hready_resp` is held 0 for 5 cycles while port 1 requests → the request is buffered and issued on the first ready cycle. `src_hready[1]` is low until its data phase completes.
- Exclusive pair: port 0 does LR then SC to 0x100, with port 1 writing 0x100 in between → `dst_hmaster` is correct per phase, and the SC returns `src_hexokay[0]`=0 from the slave.
- Continuous requests on both ports for 100 cycles → grants alternate 0,1,0,1 with no port waiting more than 1 grant.
- Reset asserted with port 1 buffered → all outputs at reset values, `pend_v`=0, and no ghost NONSEQ after release.
